// File: rtl/xge_pkt_pkg.sv
// xge_pkt_pkg: shared types and byte-level helpers for the xge_mac packet generator and RX checker.
// Contents: FSM state enum, word/length/index widths, payload byte function, frame length clamp.
// No logic of its own; pure typedefs, localparams and functions.
package xge_pkt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_FIN  = 2'd3
    } tx_state_t;

    localparam int WORD_BYTES = 8;
    localparam int LEN_W      = 14;  // frame length in bytes
    localparam int IDX_W      = 11;  // word index within a frame

    // Payload byte n of a frame; only the low 8 bits of n matter (8-bit modulo).
    function automatic logic [7:0] byte_lane(input logic [7:0] seed, input logic [7:0] n);
        return seed + n;
    endfunction

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                   input logic [LEN_W-1:0] lo,
                                                   input logic [LEN_W-1:0] hi);
        if (len < lo) begin
            return lo;
        end
        if (len > hi) begin
            return hi;
        end
        return len;
    endfunction

endpackage

// File: rtl/pkt_word_build.sv
// pkt_word_build: assembles one 64-bit frame word from the seed, word index and frame length.
// Ports: seed_i, word_idx_i, len_i in; word_o out (byte k in [8k+7:8k], zero past len_i).
// Purely combinational, no latency and no flow control.
module pkt_word_build
    import xge_pkt_pkg::*;
(
    input  logic [7:0]       seed_i,
    input  logic [IDX_W-1:0] word_idx_i,
    input  logic [LEN_W-1:0] len_i,
    output logic [63:0]      word_o
);

    always_comb begin
        word_o = '0;
        for (int k = 0; k < WORD_BYTES; k++) begin
            // {word_idx, k} is the absolute byte offset n = 8*idx + k.
            if ({word_idx_i, 3'(k)} < len_i) begin
                word_o[8*k +: 8] = byte_lane(seed_i, {word_idx_i[4:0], 3'(k)});
            end
        end
    end

endmodule

// File: rtl/pkt_tx_gen.sv
// pkt_tx_gen: programmable burst frame generator driving the xge_mac pkt_tx_* interface.
// Ports: start + cfg_len/cfg_count/cfg_seed, pkt_tx_full in; pkt_tx_data/val/sop/eop/mod, busy, done, frames_sent out.
// First sop visible 2 cycles after start; pkt_tx_full stalls the word stream with 1 cycle reaction latency.
module pkt_tx_gen
    import xge_pkt_pkg::*;
#(
    parameter int MIN_LEN    = 64,
    parameter int MAX_LEN    = 9600,
    parameter int IPG_CYCLES = 2
) (
    input  logic             clk_156m25,
    input  logic             reset_156m25,
    input  logic             start,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [15:0]      cfg_count,
    input  logic [7:0]       cfg_seed,
    input  logic             pkt_tx_full,
    output logic [63:0]      pkt_tx_data,
    output logic             pkt_tx_val,
    output logic             pkt_tx_sop,
    output logic             pkt_tx_eop,
    output logic [2:0]       pkt_tx_mod,
    output logic             busy,
    output logic             done,
    output logic [31:0]      frames_sent
);

    localparam int GAP_W = 8;
    // The gap counter is loaded on the eop edge, so it counts IPG_CYCLES-1 down to 0.
    localparam logic [GAP_W-1:0] GAP_LOAD = (IPG_CYCLES > 0) ? GAP_W'(IPG_CYCLES - 1) : GAP_W'(0);

    tx_state_t        state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [7:0]       seed_q, seed_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [63:0]      data_q, data_d;
    logic             val_q, val_d;
    logic             sop_q, sop_d;
    logic             eop_q, eop_d;
    logic [2:0]       tx_mod_q, tx_mod_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [31:0]      frames_q, frames_d;

    logic [IDX_W-1:0] last_idx;
    logic             word_go;
    logic             last_word;
    logic [63:0]      word;

    assign last_idx  = IDX_W'((len_q + LEN_W'(7)) >> 3) - IDX_W'(1);
    assign word_go   = (state_q == ST_SEND) && !pkt_tx_full;
    assign last_word = (idx_q == last_idx);

    pkt_word_build u_word_build (
        .seed_i     (seed_q),
        .word_idx_i (idx_q),
        .len_i      (len_q),
        .word_o     (word)
    );

    always_ff @(posedge clk_156m25 or posedge reset_156m25) begin
        if (reset_156m25) begin
            state_q  <= ST_IDLE;
            len_q    <= '0;
            cnt_q    <= '0;
            seed_q   <= '0;
            idx_q    <= '0;
            gap_q    <= '0;
            data_q   <= '0;
            val_q    <= 1'b0;
            sop_q    <= 1'b0;
            eop_q    <= 1'b0;
            tx_mod_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            frames_q <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            seed_q   <= seed_d;
            idx_q    <= idx_d;
            gap_q    <= gap_d;
            data_q   <= data_d;
            val_q    <= val_d;
            sop_q    <= sop_d;
            eop_q    <= eop_d;
            tx_mod_q <= tx_mod_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            frames_q <= frames_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (cfg_count == 16'd0) ? ST_FIN : ST_SEND;
                end
            end
            ST_SEND: begin
                if (word_go && last_word) begin
                    if (cnt_q == 16'd1) begin
                        state_d = ST_FIN;
                    end else if (IPG_CYCLES == 0) begin
                        state_d = ST_SEND;
                    end else begin
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d = ST_SEND;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        len_d    = len_q;
        cnt_d    = cnt_q;
        seed_d   = seed_q;
        idx_d    = idx_q;
        gap_d    = gap_q;
        data_d   = data_q;  // data holds through stalls and idle
        val_d    = 1'b0;
        sop_d    = 1'b0;
        eop_d    = 1'b0;
        tx_mod_d = '0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        frames_d = frames_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d  = clamp_len(cfg_len, LEN_W'(MIN_LEN), LEN_W'(MAX_LEN));
                    cnt_d  = cfg_count;
                    seed_d = cfg_seed;
                    idx_d  = '0;
                    busy_d = (cfg_count != 16'd0);
                end
            end
            ST_SEND: begin
                if (word_go) begin
                    data_d = word;
                    val_d  = 1'b1;
                    sop_d  = (idx_q == '0);
                    if (last_word) begin
                        eop_d    = 1'b1;
                        tx_mod_d = len_q[2:0];
                        idx_d    = '0;
                        cnt_d    = cnt_q - 16'd1;
                        frames_d = frames_q + 32'd1;
                        gap_d    = GAP_LOAD;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_GAP: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            ST_FIN: begin
                done_d = 1'b1;
                busy_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign pkt_tx_data = data_q;
    assign pkt_tx_val  = val_q;
    assign pkt_tx_sop  = sop_q;
    assign pkt_tx_eop  = eop_q;
    assign pkt_tx_mod  = tx_mod_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign frames_sent = frames_q;

endmodule

// File: tb/tb_pkt_tx_gen.sv
// tb_pkt_tx_gen: scenario tasks for pkt_tx_gen, checked against a byte-stream frame model.
// Ports: none; drives the DUT, records every valid word and done pulse at the falling edge.
// Inputs change just after the rising edge; outputs are sampled at the falling edge.
module tb_pkt_tx_gen;

    localparam int MIN_LEN = 64;
    localparam int MAX_LEN = 9600;
    localparam int IPG     = 2;

    logic        clk_156m25   = 1'b0;
    logic        reset_156m25 = 1'b1;
    logic        start        = 1'b0;
    logic [13:0] cfg_len      = '0;
    logic [15:0] cfg_count    = '0;
    logic [7:0]  cfg_seed     = '0;
    logic        pkt_tx_full  = 1'b0;
    logic [63:0] pkt_tx_data;
    logic        pkt_tx_val;
    logic        pkt_tx_sop;
    logic        pkt_tx_eop;
    logic [2:0]  pkt_tx_mod;
    logic        busy;
    logic        done;
    logic [31:0] frames_sent;

    pkt_tx_gen #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .IPG_CYCLES(IPG)) dut (
        .clk_156m25   (clk_156m25),
        .reset_156m25 (reset_156m25),
        .start        (start),
        .cfg_len      (cfg_len),
        .cfg_count    (cfg_count),
        .cfg_seed     (cfg_seed),
        .pkt_tx_full  (pkt_tx_full),
        .pkt_tx_data  (pkt_tx_data),
        .pkt_tx_val   (pkt_tx_val),
        .pkt_tx_sop   (pkt_tx_sop),
        .pkt_tx_eop   (pkt_tx_eop),
        .pkt_tx_mod   (pkt_tx_mod),
        .busy         (busy),
        .done         (done),
        .frames_sent  (frames_sent)
    );

    always #5 clk_156m25 = ~clk_156m25;

    int cyc = 0;
    always @(posedge clk_156m25) cyc <= cyc + 1;

    logic [63:0] mon_data[$];
    bit          mon_sop[$];
    bit          mon_eop[$];
    logic [2:0]  mon_mod[$];
    int          mon_cyc[$];
    int          done_cyc[$];

    always @(negedge clk_156m25) begin
        if (pkt_tx_val) begin
            mon_data.push_back(pkt_tx_data);
            mon_sop.push_back(pkt_tx_sop);
            mon_eop.push_back(pkt_tx_eop);
            mon_mod.push_back(pkt_tx_mod);
            mon_cyc.push_back(cyc);
        end
        if (done) done_cyc.push_back(cyc);
    end

    int checks     = 0;
    int failures   = 0;
    int exp_frames = 0;

    function automatic int eff_len(input int len);
        if (len < MIN_LEN) return MIN_LEN;
        if (len > MAX_LEN) return MAX_LEN;
        return len;
    endfunction

    // Builds the expected frame as a byte stream padded to whole words, then compares the
    // recorded words (frame repeated nfr times). Returns the number of discrepancies.
    function automatic int frame_errs(input int len, input int nfr, input logic [7:0] seed, input bit partial);
        int eff = eff_len(len);
        int nw = (eff + 7) / 8;
        byte unsigned fb[$];
        int errs = 0;
        for (int n = 0; n < nw * 8; n++) begin
            if (n < eff) fb.push_back(8'((seed + n) % 256));
            else fb.push_back(8'd0);
        end
        if (!partial && mon_data.size() != nw * nfr) errs++;
        for (int i = 0; i < mon_data.size() && i < nw * nfr; i++) begin
            int w = i % nw;
            logic [63:0] ew;
            for (int k = 0; k < 8; k++) ew[8*k +: 8] = fb[w*8 + k];
            if (mon_data[i] !== ew) errs++;
            if (mon_sop[i] != (w == 0)) errs++;
            if (mon_eop[i] != (w == nw - 1)) errs++;
            if (w == nw - 1 && mon_mod[i] !== 3'(eff % 8)) errs++;
        end
        return errs;
    endfunction

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk_156m25);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
    endtask

    task automatic do_start(input int len, input int cnt, input logic [7:0] seed, output int scyc);
        @(posedge clk_156m25); #1;
        mon_data.delete(); mon_sop.delete(); mon_eop.delete();
        mon_mod.delete(); mon_cyc.delete(); done_cyc.delete();
        cfg_len = 14'(len); cfg_count = 16'(cnt); cfg_seed = seed;
        start = 1'b1;
        scyc = cyc;
        @(posedge clk_156m25); #1;
        start = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk_156m25);
        checks++;
        if ({pkt_tx_data, pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod} !== '0) begin
            failures++;
            $display("FAIL reset_tx: data=%h val=%b sop=%b eop=%b mod=%0d, want all 0",
                     pkt_tx_data, pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || frames_sent !== 32'd0) begin
            failures++;
            $display("FAIL reset_status: busy=%b done=%b frames=%0d, want 0 0 0", busy, done, frames_sent);
        end
        @(posedge clk_156m25); #1 reset_156m25 = 1'b0;
        repeat (3) @(negedge clk_156m25);
        checks++;
        if (busy !== 1'b0 || pkt_tx_val !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: busy=%b val=%b after release, want 0 0", busy, pkt_tx_val);
        end
    endtask

    task automatic test_basic;
        int s;
        bit ok;
        do_start(64, 1, 8'h00, s);
        wait_done(100, ok);
        exp_frames += 1;
        checks++;
        if (!ok) begin failures++; $display("FAIL basic_done: no done within 100 cycles"); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy: busy=%b in done cycle, want 0", busy); end
        checks++;
        if (mon_data.size() != 8) begin
            failures++; $display("FAIL basic_words: got %0d words, want 8", mon_data.size());
        end else begin
            checks++;
            if (mon_data[0] !== 64'h0706050403020100 || !mon_sop[0]) begin
                failures++; $display("FAIL basic_word0: data=%h sop=%b, want 0706050403020100 sop=1", mon_data[0], mon_sop[0]);
            end
            checks++;
            if (mon_data[7] !== 64'h3F3E3D3C3B3A3938 || !mon_eop[7] || mon_mod[7] !== 3'd0) begin
                failures++; $display("FAIL basic_word7: data=%h eop=%b mod=%0d, want 3F3E3D3C3B3A3938 eop=1 mod=0",
                                     mon_data[7], mon_eop[7], mon_mod[7]);
            end
            checks++;
            if (mon_cyc[0] != s + 2) begin
                failures++; $display("FAIL basic_latency: sop at +%0d cycles, want +2", mon_cyc[0] - s);
            end
            checks++;
            if (mon_cyc[7] - mon_cyc[0] != 7) begin
                failures++; $display("FAIL basic_contig: 8 words over %0d cycles, want 8", mon_cyc[7] - mon_cyc[0] + 1);
            end
            checks++;
            if (done_cyc.size() != 1 || done_cyc[0] != mon_cyc[7] + 1) begin
                failures++; $display("FAIL basic_done_timing: %0d done pulses, first %0d, want 1 at %0d",
                                     done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, mon_cyc[7] + 1);
            end
        end
        checks++;
        if (frames_sent !== 32'(exp_frames)) begin
            failures++; $display("FAIL basic_frames: got %0d, want %0d", frames_sent, exp_frames);
        end
    endtask

    task automatic test_len65;
        int s;
        bit ok;
        int e;
        do_start(65, 1, 8'hFE, s);
        wait_done(100, ok);
        exp_frames += 1;
        checks++;
        if (!ok) begin failures++; $display("FAIL len65_done: no done within 100 cycles"); end
        e = frame_errs(65, 1, 8'hFE, 1'b0);
        checks++;
        if (e != 0) begin failures++; $display("FAIL len65_model: %0d discrepancies, want 0", e); end
        checks++;
        if (mon_data.size() != 9) begin
            failures++; $display("FAIL len65_words: got %0d words, want 9", mon_data.size());
        end else begin
            checks++;
            if (mon_data[0] !== 64'h050403020100FFFE) begin
                failures++; $display("FAIL len65_word0: data=%h, want 050403020100FFFE", mon_data[0]);
            end
            checks++;
            if (mon_data[8] !== 64'h000000000000003E || !mon_eop[8] || mon_mod[8] !== 3'd1) begin
                failures++; $display("FAIL len65_word8: data=%h eop=%b mod=%0d, want 3E eop=1 mod=1",
                                     mon_data[8], mon_eop[8], mon_mod[8]);
            end
        end
    endtask

    task automatic test_backpressure;
        int s;
        bit ok;
        bit hit;
        int seen;
        int e;
        logic [7:0] seed;
        seed = 8'($urandom);
        hit = 1'b0;
        seen = 0;
        do_start(128, 1, seed, s);
        for (int c = 0; c < 50; c++) begin
            @(negedge clk_156m25);
            if (pkt_tx_val) seen++;
            if (seen == 6) begin hit = 1'b1; break; end
        end
        pkt_tx_full = 1'b1;
        repeat (3) @(posedge clk_156m25);
        #1 pkt_tx_full = 1'b0;
        wait_done(100, ok);
        exp_frames += 1;
        checks++;
        if (!hit || !ok) begin failures++; $display("FAIL bp_progress: word5 seen=%b done seen=%b, want 1 1", hit, ok); end
        e = frame_errs(128, 1, seed, 1'b0);
        checks++;
        if (e != 0) begin failures++; $display("FAIL bp_model: %0d discrepancies over %0d words, want 0 over 16", e, mon_data.size()); end
        checks++;
        if (mon_cyc.size() < 7 || mon_cyc[6] - mon_cyc[5] != 4) begin
            failures++; $display("FAIL bp_stall: word5->word6 spacing %0d, want 4",
                                 (mon_cyc.size() >= 7) ? mon_cyc[6] - mon_cyc[5] : -1);
        end
    endtask

    task automatic test_multi_frame;
        int s;
        bit ok;
        int e;
        int len;
        int gap_bad;
        logic [7:0] seed;
        len = $urandom_range(64, 200);
        seed = 8'($urandom);
        gap_bad = 0;
        do_start(len, 3, seed, s);
        wait_done(300, ok);
        exp_frames += 3;
        repeat (5) @(negedge clk_156m25);
        #1;
        checks++;
        if (!ok) begin failures++; $display("FAIL multi_done: no done within 300 cycles"); end
        e = frame_errs(len, 3, seed, 1'b0);
        checks++;
        if (e != 0) begin failures++; $display("FAIL multi_model: len=%0d %0d discrepancies, want 0", len, e); end
        for (int i = 0; i + 1 < mon_cyc.size(); i++) begin
            if (mon_eop[i] && mon_cyc[i+1] - mon_cyc[i] != IPG + 1) gap_bad++;
        end
        checks++;
        if (gap_bad != 0) begin failures++; $display("FAIL multi_gap: %0d gaps not eop->sop = %0d cycles", gap_bad, IPG + 1); end
        checks++;
        if (done_cyc.size() != 1) begin failures++; $display("FAIL multi_done_count: got %0d pulses, want 1", done_cyc.size()); end
        checks++;
        if (frames_sent !== 32'(exp_frames)) begin
            failures++; $display("FAIL multi_frames: got %0d, want %0d", frames_sent, exp_frames);
        end
    endtask

    task automatic test_clamp;
        int s;
        bit ok;
        int e;
        logic [7:0] seed;
        seed = 8'($urandom);
        do_start(20, 1, seed, s);
        wait_done(100, ok);
        exp_frames += 1;
        e = frame_errs(20, 1, seed, 1'b0);
        checks++;
        if (!ok || e != 0 || mon_data.size() != 8) begin
            failures++; $display("FAIL clamp_min: done=%b words=%0d errs=%0d, want 1 8 0", ok, mon_data.size(), e);
        end
        seed = 8'($urandom);
        do_start(10000, 1, seed, s);
        wait_done(1400, ok);
        exp_frames += 1;
        e = frame_errs(10000, 1, seed, 1'b0);
        checks++;
        if (!ok || e != 0 || mon_data.size() != 1200) begin
            failures++; $display("FAIL clamp_max: done=%b words=%0d errs=%0d, want 1 1200 0", ok, mon_data.size(), e);
        end
    endtask

    task automatic test_start_busy_reset;
        int s;
        bit ok;
        int e;
        int neop;
        logic [7:0] seed;
        seed = 8'($urandom);
        neop = 0;
        do_start(64, 2, seed, s);
        @(posedge clk_156m25); #1;
        cfg_len = 14'd200; cfg_count = 16'd7; cfg_seed = ~seed; start = 1'b1;
        @(posedge clk_156m25); #1 start = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk_156m25); #1;
            if (mon_data.size() >= 5) break;
        end
        reset_156m25 = 1'b1;
        exp_frames = 0;
        #1;
        checks++;
        if ({pkt_tx_data, pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, busy, done} !== '0 || frames_sent !== 32'(exp_frames)) begin
            failures++; $display("FAIL rst_async: data=%h val=%b sop=%b eop=%b mod=%0d busy=%b done=%b frames=%0d, want all 0",
                                 pkt_tx_data, pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, busy, done, frames_sent);
        end
        e = frame_errs(64, 2, seed, 1'b1);
        foreach (mon_eop[i]) if (mon_eop[i]) neop++;
        checks++;
        if (mon_data.size() != 5 || e != 0 || neop != 0) begin
            failures++; $display("FAIL rst_partial: words=%0d errs=%0d eops=%0d, want 5 0 0", mon_data.size(), e, neop);
        end
        repeat (2) @(posedge clk_156m25);
        #1 reset_156m25 = 1'b0;
        repeat (3) @(negedge clk_156m25);
        checks++;
        if (busy !== 1'b0 || pkt_tx_val !== 1'b0 || mon_data.size() != 5) begin
            failures++; $display("FAIL rst_idle: busy=%b val=%b words=%0d after release, want 0 0 5", busy, pkt_tx_val, mon_data.size());
        end
        seed = 8'($urandom);
        do_start(64, 2, seed, s);
        wait_done(200, ok);
        exp_frames += 2;
        e = frame_errs(64, 2, seed, 1'b0);
        checks++;
        if (!ok || e != 0) begin failures++; $display("FAIL rst_rerun: done=%b errs=%0d, want 1 0", ok, e); end
        checks++;
        if (frames_sent !== 32'(exp_frames)) begin
            failures++; $display("FAIL rst_frames: got %0d, want %0d", frames_sent, exp_frames);
        end
    endtask

    task automatic test_random;
        int s;
        bit ok;
        int e;
        int len;
        int cnt;
        int gap_bad;
        logic [7:0] seed;
        for (int it = 0; it < 6; it++) begin
            len = $urandom_range(1, 400);
            cnt = $urandom_range(1, 3);
            seed = 8'($urandom);
            gap_bad = 0;
            ok = 1'b0;
            do_start(len, cnt, seed, s);
            for (int c = 0; c < 3000 && !ok; c++) begin
                @(posedge clk_156m25); #1 pkt_tx_full = ($urandom_range(0, 99) < 30);
                @(negedge clk_156m25);
                if (done) ok = 1'b1;
            end
            #1 pkt_tx_full = 1'b0;
            exp_frames += cnt;
            e = frame_errs(len, cnt, seed, 1'b0);
            for (int i = 0; i + 1 < mon_cyc.size(); i++) begin
                if (mon_eop[i] && mon_cyc[i+1] - mon_cyc[i] < IPG + 1) gap_bad++;
            end
            checks++;
            if (!ok || e != 0 || gap_bad != 0) begin
                failures++; $display("FAIL rand_burst%0d: len=%0d cnt=%0d done=%b errs=%0d short_gaps=%0d, want done=1 0 0",
                                     it, len, cnt, ok, e, gap_bad);
            end
            checks++;
            if (frames_sent !== 32'(exp_frames)) begin
                failures++; $display("FAIL rand_frames%0d: got %0d, want %0d", it, frames_sent, exp_frames);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_len65();
        test_backpressure();
        test_multi_frame();
        test_clamp();
        test_start_busy_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pkt_tx_gen.md
Name: pkt_tx_gen

Overview:
- Programmable frame generator that drives the xge_mac packet-transmit interface (pkt_tx_data/val/sop/eop/mod) and honours pkt_tx_full back-pressure.
- Sits directly upstream of the MAC TX FIFO in the 156.25 MHz domain.
- Provides a synthesizable stimulus source for XGMII-loopback bring-up and for self-checking of the MAC RX side.

Parameters:
- MIN_LEN, 64, minimum frame length in bytes; shorter requests are raised to this.
- MAX_LEN, 9600, maximum frame length in bytes; longer requests are lowered to this.
- IPG_CYCLES, 2, minimum idle cycles with pkt_tx_val low between consecutive frames.

Ports:
- clk_156m25  in  1  system clock, 156.25 MHz.
- reset_156m25  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; latches cfg_* and begins a burst.
- cfg_len  in  14  frame length in bytes.
- cfg_count  in  16  number of frames in the burst.
- cfg_seed  in  8  payload seed byte.
- pkt_tx_full  in  1  MAC TX FIFO almost-full.
- pkt_tx_data  out  64  frame word; byte k of the word is in [8k+7:8k].
- pkt_tx_val  out  1  word valid.
- pkt_tx_sop  out  1  first word of frame.
- pkt_tx_eop  out  1  last word of frame.
- pkt_tx_mod  out  3  valid bytes in the eop word; 0 means all 8 are valid.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse when the burst completes.
- frames_sent  out  32  total frames emitted since reset; wraps.

Behaviour:
- Clock and reset: one clock, clk_156m25. reset_156m25 is asynchronous and active-high.
- Registered outputs: every output is a flop.
- Reset values: all outputs 0, state IDLE, all counters 0.
- Start and latching:
  - start is honoured only in IDLE; start while busy is ignored.
  - On start, latch len_q = clamp(cfg_len, MIN_LEN, MAX_LEN), cnt_q = cfg_count, seed_q = cfg_seed.
- Derived values:
  - nwords = ceil(len_q/8).
  - mod_q = len_q[2:0].
- Payload:
  - Byte n of a frame (n = 0 .. len_q-1) = (seed_q + n) mod 256.
  - Bytes at or beyond len_q in the eop word are 0.
  - Each frame restarts at n = 0, so every frame has identical content.
- FSM states: IDLE, SEND, GAP, FIN.
  - IDLE: busy=0. On start with cfg_count==0, go to FIN. On start otherwise, go to SEND, with busy=1 from the next cycle.
  - SEND: on each edge where pkt_tx_full==0, register the next word with val=1.
    - sop=1 when word index is 0.
    - eop=1 and mod=mod_q when word index is nwords-1.
    - On the edge where pkt_tx_full==1, register val=0, sop=0, eop=0. Data is don't-care; hold its previous value. The word index does not advance.
  - Frame end: after the eop word is registered, increment frames_sent and decrement cnt_q. Go to GAP if cnt_q is not yet 0; otherwise go to FIN.
  - GAP: val=0 for exactly IPG_CYCLES cycles, then SEND. The next sop appears no earlier than IPG_CYCLES+1 cycles after the eop cycle, and later if full is high. IPG_CYCLES=0 means no GAP state.
  - FIN: val=0, done=1 for one cycle, busy=0 in the same cycle, then IDLE.
- Back-pressure:
  - Reaction latency to pkt_tx_full is 1 cycle; the MAC's almost-full slack absorbs it.
  - No word is dropped or duplicated across full stalls.
  - full during GAP or IDLE has no effect.
- Start latency: the first sop is registered on the second edge after start is sampled, i.e. visible 2 cycles after the start pulse.
- Width rules:
  - Word index is 11 bits.
  - Byte arithmetic is 8-bit modulo.
  - frames_sent wraps from 0xFFFFFFFF to 0 silently.
- Reset mid-frame: all outputs clear immediately (asynchronous). No eop is emitted for the partial frame. After release, the block is in IDLE awaiting start.

Decomposition:
- Shared package xge_pkt_pkg:
  - enum for the FSM states.
  - localparam WORD_BYTES=8.
  - function byte_lane(seed, n) returning (seed+n) mod 256.
  - function clamp_len.
  - The package is reused by the RX checker.
- One natural sub-module, pkt_word_build: combinational assembly of the 64-bit word from seed_q, word index and len_q, with zero fill past len_q. The FSM and counters remain in pkt_tx_gen.

Test Plan:
- cfg_len=64, cfg_count=1, cfg_seed=0x00, full=0 -> 8 consecutive val words; word0 = 0x0706050403020100 with sop=1; word7 = 0x3F3E3D3C3B3A3938 with eop=1, mod=0; done pulse 1 cycle after eop; frames_sent=1.
- cfg_len=65, cfg_seed=0xFE -> 9 words; word0 = 0x050403020100FFFE; word8 = 0x000000000000003E with eop=1, mod=1.
- cfg_len=128, hold pkt_tx_full=1 for 3 cycles after word 5 -> val low for exactly 3 cycles starting 1 cycle after full rises; word 6 follows with correct data; 16 words total, none repeated.
- cfg_count=3, IPG_CYCLES=2 -> 3 frames; at least 2 val-low cycles between each eop and the next sop; frames_sent=3; done asserted once.
- cfg_len=20 -> frame of 64 bytes (8 words). cfg_len=10000 -> frame of 9600 bytes (1200 words, mod=0).
- Pulse start while busy, then assert reset_156m25 at word 4 of a 2-frame burst -> start ignored; all outputs 0 asynchronously; after release busy=0 and a new start runs a full burst from word 0.
